mem_seg: RTL and testbench

Memory-access (MEM) pipeline segment of the R/I/J CPU, sitting directly downstream of the execute segment. Consumes the execute stage's instruction, ALU result, store operand and branch condition; performs data-memory loads and stores against an internal word-addressed data RAM with configurable wait states; stalls upstream while an access is in flight. Registers the results (LMD, ALU result, IR) for write-back and issues the branch/jump PC redirect.

---
 rtl/mem_seg_if.sv | 25 ++
 rtl/mem_seg.sv | 174 +++++++++++++++++
 tb/tb_mem_seg.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_seg_if.sv
// rtl/mem_seg_if.sv - execute-to-MEM inputs and MEM-to-writeback outputs of the memory segment
interface mem_seg_if;
  logic [31:0] IRi;
  logic [31:0] ALUi;
  logic [31:0] Bi;
  logic        condi;
  logic        validi;
  logic        stall;
  logic [31:0] IRo;
  logic [31:0] ALUo;
  logic [31:0] LMDo;
  logic        valido;
  logic        pcSel;
  logic [31:0] pcTarget;

  modport slave (
    input  IRi, ALUi, Bi, condi, validi,
    output stall, IRo, ALUo, LMDo, valido, pcSel, pcTarget
  );

  modport master (
    output IRi, ALUi, Bi, condi, validi,
    input  stall, IRo, ALUo, LMDo, valido, pcSel, pcTarget
  );
endinterface

// File: rtl/mem_seg.sv
// rtl/mem_seg.sv - MEM pipeline segment: data RAM loads/stores with wait states, result registers, PC redirect
// Byte accesses (LB/LBU/SB) are built only when MEMSEG_BYTE_EN is defined.
module mem_seg #(
  parameter int ADDR_W  = 10,
  parameter int MEM_LAT = 1
) (
  input  logic     clk,
  input  logic     rst,
  mem_seg_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
`ifdef MEMSEG_BYTE_EN
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_SB  = 6'h28;
`endif

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [31:0]       ram [DEPTH];

  logic [5:0]        op;
  logic [ADDR_W-1:0] widx;
  logic [1:0]        lane;
  logic [31:0]       rword;
  logic [7:0]        rbyte;
  logic [31:0]       wdata;
  logic [31:0]       ld_data;
  logic              is_lw, is_sw, is_lb, is_lbu, is_sb;
  logic              is_store, is_mem, taken, accept;

  logic [31:0]       h_ir, h_alu, h_lmd;
  logic              hold_en;

  logic [31:0]       ir_q, alu_q, lmd_q, tgt_q;
  logic              valid_q, sel_q;
  logic [31:0]       ir_n, alu_n, lmd_n, tgt_n;
  logic              valid_n, sel_n;

  assign op     = bus.IRi[31:26];
  assign widx   = bus.ALUi[ADDR_W+1:2];
  assign lane   = bus.ALUi[1:0];
  assign rword  = ram[widx];
  assign rbyte  = rword[{lane, 3'b000} +: 8];
  assign accept = bus.validi && (state == S_IDLE);

  always_comb begin
    is_lw  = (op == OP_LW);
    is_sw  = (op == OP_SW);
`ifdef MEMSEG_BYTE_EN
    is_lb  = (op == OP_LB);
    is_lbu = (op == OP_LBU);
    is_sb  = (op == OP_SB);
`else
    is_lb  = 1'b0;
    is_lbu = 1'b0;
    is_sb  = 1'b0;
`endif
    is_store = is_sw || is_sb;
    is_mem   = is_store || is_lw || is_lb || is_lbu;
    taken    = (((op == OP_BEQ) || (op == OP_BNE)) && bus.condi) ||
               (op == OP_J) || (op == OP_JAL);
  end

  // Loads see the word as it stands before this edge; byte stores merge into it.
  always_comb begin
    ld_data = 32'h0;
    if (is_lw)
      ld_data = rword;
    else if (is_lb)
      ld_data = {{24{rbyte[7]}}, rbyte};
    else if (is_lbu)
      ld_data = {24'h0, rbyte};

    wdata = bus.Bi;
    if (is_sb) begin
      wdata = rword;
      wdata[{lane, 3'b000} +: 8] = bus.Bi[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst && accept && is_store)
      ram[widx] <= wdata;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hold_en   = 1'b0;
    valid_n   = 1'b0;
    ir_n      = 32'h0;
    alu_n     = 32'h0;
    lmd_n     = 32'h0;
    sel_n     = 1'b0;
    tgt_n     = 32'h0;
    case (state)
      S_IDLE: begin
        if (bus.validi) begin
          if (is_mem && (MEM_LAT > 0)) begin
            state_nxt = S_WAIT;
            cnt_nxt   = 4'(MEM_LAT);
            hold_en   = 1'b1;
          end else begin
            valid_n = 1'b1;
            ir_n    = bus.IRi;
            alu_n   = bus.ALUi;
            lmd_n   = ld_data;
            sel_n   = taken;
            tgt_n   = taken ? bus.ALUi : 32'h0;
          end
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = S_IDLE;
          valid_n   = 1'b1;
          ir_n      = h_ir;
          alu_n     = h_alu;
          lmd_n     = h_lmd;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      h_ir    <= 32'h0;
      h_alu   <= 32'h0;
      h_lmd   <= 32'h0;
      valid_q <= 1'b0;
      ir_q    <= 32'h0;
      alu_q   <= 32'h0;
      lmd_q   <= 32'h0;
      sel_q   <= 1'b0;
      tgt_q   <= 32'h0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      valid_q <= valid_n;
      ir_q    <= ir_n;
      alu_q   <= alu_n;
      lmd_q   <= lmd_n;
      sel_q   <= sel_n;
      tgt_q   <= tgt_n;
      if (hold_en) begin
        h_ir  <= bus.IRi;
        h_alu <= bus.ALUi;
        h_lmd <= ld_data;
      end
    end
  end

  assign bus.stall    = (state == S_WAIT);
  assign bus.valido   = valid_q;
  assign bus.IRo      = ir_q;
  assign bus.ALUo     = alu_q;
  assign bus.LMDo     = lmd_q;
  assign bus.pcSel    = sel_q;
  assign bus.pcTarget = tgt_q;
endmodule

// File: tb/tb_mem_seg.sv
// tb/tb_mem_seg.sv - randomized bench for mem_seg against a transaction-level memory/pipeline model
module tb_mem_seg;
  localparam int AW    = 10;
  localparam int LAT   = 1;
  localparam int DEPTH = 1 << AW;
`ifdef MEMSEG_BYTE_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  typedef struct {
    logic        valid;
    logic [31:0] ir;
    logic [31:0] alu;
    logic [31:0] lmd;
    logic        sel;
    logic [31:0] tgt;
    bit          lmd_ok;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_seg_if bus();
  mem_seg #(.ADDR_W(AW), .MEM_LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  logic [31:0] mram [int];
  out_t exp_o, pend;
  logic exp_stall = 1'b0;
  int   wait_left = 0;

  function automatic out_t zero_out();
    out_t z;
    z = '{valid: 1'b0, ir: 32'h0, alu: 32'h0, lmd: 32'h0, sel: 1'b0, tgt: 32'h0, lmd_ok: 1'b1};
    return z;
  endfunction

  function automatic bit mem_op(input logic [5:0] op);
    if (op == 6'h23 || op == 6'h2B) return 1'b1;
    if (op == 6'h20 || op == 6'h24 || op == 6'h28) return BYTE_EN;
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_assert++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, expv, $time);
    end
  endtask

  // Architectural effect of one accepted instruction.
  task automatic exec_insn(output out_t r);
    logic [5:0]  op;
    int          idx;
    int          sh;
    logic [31:0] w, b8;
    op  = bus.IRi[31:26];
    idx = int'((bus.ALUi >> 2) % DEPTH);
    sh  = 8 * int'(bus.ALUi % 4);
    r = '{valid: 1'b1, ir: bus.IRi, alu: bus.ALUi, lmd: 32'h0, sel: 1'b0, tgt: 32'h0, lmd_ok: 1'b1};
    w  = mram.exists(idx) ? mram[idx] : 32'h0;
    b8 = (w >> sh) & 32'hFF;
    if (op == 6'h2B) mram[idx] = bus.Bi;
    else if (op == 6'h23) begin
      r.lmd = w; r.lmd_ok = mram.exists(idx);
    end else if (BYTE_EN && op == 6'h28) begin
      if (mram.exists(idx)) mram[idx] = (w & ~(32'hFF << sh)) | ((bus.Bi & 32'hFF) << sh);
    end else if (BYTE_EN && op == 6'h20) begin
      r.lmd = (b8 >= 32'd128) ? b8 - 32'd256 : b8; r.lmd_ok = mram.exists(idx);
    end else if (BYTE_EN && op == 6'h24) begin
      r.lmd = b8; r.lmd_ok = mram.exists(idx);
    end else if (((op == 6'h04 || op == 6'h05) && bus.condi) || op == 6'h02 || op == 6'h03) begin
      r.sel = 1'b1; r.tgt = bus.ALUi;
    end
  endtask

  task automatic model_edge();
    out_t r;
    if (wait_left > 0) begin
      wait_left--;
      exp_o = (wait_left == 0) ? pend : zero_out();
    end else if (bus.validi) begin
      exec_insn(r);
      if (mem_op(bus.IRi[31:26]) && LAT > 0) begin
        pend = r; wait_left = LAT; exp_o = zero_out();
      end else exp_o = r;
    end else exp_o = zero_out();
    exp_stall = (wait_left > 0);
  endtask

  task automatic issue(input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] b,
                       input logic cond, input logic valid);
    bit acc;
    bus.IRi = ir; bus.ALUi = alu; bus.Bi = b; bus.condi = cond; bus.validi = valid;
    do begin
      acc = (wait_left == 0);
      model_edge();
      @(negedge clk);
    end while (!acc);
  endtask

  task automatic run_to_output();
    while (wait_left > 0) begin
      model_edge();
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; bus.validi = 1'b0;
    wait_left = 0; exp_o = zero_out(); exp_stall = 1'b0;
    #1;
    check("rst_valido", 32'(bus.valido), 32'h0);
    check("rst_stall", 32'(bus.stall), 32'h0);
    check("rst_pcsel", 32'(bus.pcSel), 32'h0);
    check("rst_iro", bus.IRo, 32'h0);
    check("rst_lmdo", bus.LMDo, 32'h0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  always @(posedge clk) begin
    #2;
    if (chk_on) begin
      check("stall", 32'(bus.stall), 32'(exp_stall));
      check("valido", 32'(bus.valido), 32'(exp_o.valid));
      check("iro", bus.IRo, exp_o.ir);
      check("aluo", bus.ALUo, exp_o.alu);
      check("pcsel", 32'(bus.pcSel), 32'(exp_o.sel));
      check("pctarget", bus.pcTarget, exp_o.tgt);
      if (exp_o.lmd_ok) check("lmdo", bus.LMDo, exp_o.lmd);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] ADD = 32'h00221820;
  logic [5:0] ops [12] = '{6'h23, 6'h2B, 6'h20, 6'h24, 6'h28, 6'h04,
                           6'h05, 6'h02, 6'h03, 6'h00, 6'h08, 6'h0D};

  initial begin
    logic [31:0] r, alu;
    logic [5:0]  op;
    exp_o = zero_out(); pend = zero_out();
    bus.IRi = 32'h0; bus.ALUi = 32'h0; bus.Bi = 32'h0; bus.condi = 1'b0; bus.validi = 1'b0;
    @(negedge clk);
    do_reset();
    chk_on = 1'b1;

    for (int k = 0; k < 8; k++) issue({6'h2B, 26'h0}, 32'(4 * k), $urandom(), 1'b0, 1'b1);

    issue({6'h2B, 26'h1}, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1);
    check("sw_stall", 32'(bus.stall), 32'(LAT > 0));
    issue({6'h23, 26'h2}, 32'h10, 32'h0, 1'b0, 1'b1);
    run_to_output();
    check("lw_lmd", bus.LMDo, 32'hDEADBEEF);
    check("lw_valid", 32'(bus.valido), 32'h1);

    issue({6'h2B, 26'h3}, 32'h10, 32'h0, 1'b0, 1'b1);
    issue({6'h28, 26'h4}, 32'h13, 32'h00000080, 1'b0, 1'b1);
    issue({6'h20, 26'h5}, 32'h13, 32'h0, 1'b0, 1'b1);
    run_to_output();
    check("lb_lmd", bus.LMDo, BYTE_EN ? 32'hFFFFFF80 : 32'h0);
    issue({6'h24, 26'h6}, 32'h13, 32'h0, 1'b0, 1'b1);
    run_to_output();
    check("lbu_lmd", bus.LMDo, BYTE_EN ? 32'h00000080 : 32'h0);
    issue({6'h23, 26'h7}, 32'h10, 32'h0, 1'b0, 1'b1);
    run_to_output();
    check("sb_word", bus.LMDo, BYTE_EN ? 32'h80000000 : 32'h0);

    issue({6'h04, 26'h8}, 32'h40, 32'h0, 1'b1, 1'b1);
    check("beq_sel", 32'(bus.pcSel), 32'h1);
    check("beq_tgt", bus.pcTarget, 32'h40);
    issue({6'h05, 26'h9}, 32'h80, 32'h0, 1'b0, 1'b1);
    check("bne_sel", 32'(bus.pcSel), 32'h0);
    check("bne_tgt", bus.pcTarget, 32'h0);

    issue({6'h2B, 26'hA}, 32'h1004, 32'h12345678, 1'b0, 1'b1);
    issue({6'h23, 26'hB}, 32'h0004, 32'h0, 1'b0, 1'b1);
    run_to_output();
    check("wrap_lmd", bus.LMDo, 32'h12345678);

    issue(ADD, 32'h5, 32'h0, 1'b0, 1'b1);
    check("add1_valid", 32'(bus.valido), 32'h1);
    issue(ADD, 32'h6, 32'h0, 1'b0, 1'b0);
    check("bubble_valid", 32'(bus.valido), 32'h0);
    check("bubble_ir", bus.IRo, 32'h0);
    issue(ADD, 32'h7, 32'h0, 1'b0, 1'b1);
    check("add2_valid", 32'(bus.valido), 32'h1);

    issue({6'h2B, 26'hC}, 32'h20, 32'hCAFEF00D, 1'b0, 1'b1);
    do_reset();
    issue({6'h23, 26'hD}, 32'h20, 32'h0, 1'b0, 1'b1);
    run_to_output();
    check("post_rst_lmd", bus.LMDo, 32'hCAFEF00D);
    check("post_rst_valid", 32'(bus.valido), 32'h1);

    for (int i = 0; i < 700; i++) begin
      if (i == 350) do_reset();
      op = ops[$urandom_range(0, 11)];
      r  = $urandom();
      if (op == 6'h23 || op == 6'h2B || op == 6'h20 || op == 6'h24 || op == 6'h28)
        alu = {r[31:12], 7'd0, 3'($urandom_range(0, 7)), r[1:0]};
      else
        alu = $urandom();
      issue({op, 26'($urandom())}, alu, $urandom(), 1'($urandom()),
            ($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0);
    end
    run_to_output();
    issue(32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    issue(32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
